// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   (IF) and load/store (LS). LS normally wins a conflict; IF is forced to
//   win once it has lost STARVE_MAX conflicts in a row. Every read grant is
//   tagged with its owner in a MEM_LAT-deep pipeline so the response, which
//   arrives MEM_LAT cycles later, raises rvalid on the right requester.
//   An IF redirect flush kills every IF-owned read still in flight.
//
//   Optional build macro: ARB_PERF_CNT_EN
//     When defined, adds conflict_cnt_o (cycles where both sides request)
//     and starve_hit_cnt_o (forced IF wins). Both are 32-bit wrapping
//     counters. Arbitration behaviour is identical with or without it.

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  localparam int BE_W      = DATA_W / 8,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,

  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [BE_W-1:0]   ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,

`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       conflict_cnt_o,
  output logic [31:0]       starve_hit_cnt_o,
`endif

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Owner tag carried alongside each in-flight read.
  typedef enum logic {
    OWNER_LS = 1'b0,
    OWNER_IF = 1'b1
  } owner_e;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             both_req;
  logic             forced_if_win;
  logic             rd_gnt;

  logic   [MEM_LAT-1:0] tag_valid;
  owner_e               tag_owner [MEM_LAT];

  logic   tail_valid;
  owner_e tail_owner;

  assign starved       = (starve_cnt == CNT_W'(STARVE_MAX));
  assign both_req      = if_req_i & ls_req_i;
  assign forced_if_win = both_req & starved & ~reset;

  // Grant decision: a lone requester wins, LS wins a conflict unless IF has
  // hit its starvation limit. Nothing is granted while reset is held.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (!reset) begin
      if (if_req_i && (!ls_req_i || starved)) begin
        if_gnt_o = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt_o = 1'b1;
      end
    end
  end

  assign rd_gnt = if_gnt_o | (ls_gnt_o & ~ls_we_i);

  // Memory port mux: IF always reads a full word, LS drives its own fields,
  // and an idle port is driven to all zeros.
  always_comb begin
    mem_req_o   = if_gnt_o | ls_gnt_o;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (ls_gnt_o) begin
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_be_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end
  end

  // Starvation counter: counts consecutive cycles IF asks and loses,
  // saturating at the limit; any IF win or idle IF cycle restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_req_i && !if_gnt_o) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Response tag pipeline: stage 0 captures each read grant, older stages
  // shift toward the tail. A flush drops IF entries as they shift, but the
  // IF grant issued in the flush cycle itself still enters stage 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_owner[i] <= OWNER_LS;
      end
    end else begin
      tag_valid[0] <= rd_gnt;
      tag_owner[0] <= if_gnt_o ? OWNER_IF : OWNER_LS;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1] & ~(if_flush_i & (tag_owner[i-1] == OWNER_IF));
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign tail_valid = tag_valid[MEM_LAT-1];
  assign tail_owner = tag_owner[MEM_LAT-1];

  // Response steering: the tail entry qualifies rvalid for its owner; a
  // flush in the same cycle suppresses an IF response already at the tail.
  always_comb begin
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if (tail_valid) begin
      if (tail_owner == OWNER_IF) begin
        if_rvalid_o = ~if_flush_i;
      end else begin
        ls_rvalid_o = 1'b1;
      end
    end
  end

  assign if_rdata_o = mem_rdata_i;
  assign ls_rdata_o = mem_rdata_i;

`ifdef ARB_PERF_CNT_EN
  // Performance counters: conflicts and forced IF wins, free-running and
  // wrapping, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_o   <= '0;
      starve_hit_cnt_o <= '0;
    end else begin
      if (both_req) begin
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
      if (forced_if_win) begin
        starve_hit_cnt_o <= starve_hit_cnt_o + 32'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = forced_if_win;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives two arbiters (MEM_LAT=1 and MEM_LAT=2) with identical stimulus and
//   compares both against a cycle-indexed reference model: grants follow the
//   priority/starvation rule, and each read's response is expected exactly
//   MEM_LAT cycles after its issue cycle unless a flush or reset killed it.
//   Build with ARB_PERF_CNT_EN defined to also check the perf counters.

module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int STARVE_MAX = 4;
  localparam int NCYC       = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req_i, if_flush_i, ls_req_i, ls_we_i;
  logic [ADDR_W-1:0] if_addr_i, ls_addr_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [DATA_W-1:0] ls_wdata_i, mem_rdata_i;

  logic              if_gnt_l1, if_rvalid_l1, ls_gnt_l1, ls_rvalid_l1;
  logic              mem_req_l1, mem_we_l1;
  logic [BE_W-1:0]   mem_be_l1;
  logic [ADDR_W-1:0] mem_addr_l1;
  logic [DATA_W-1:0] mem_wdata_l1, if_rdata_l1, ls_rdata_l1;

  logic              if_gnt_l2, if_rvalid_l2, ls_gnt_l2, ls_rvalid_l2;
  logic              mem_req_l2, mem_we_l2;
  logic [BE_W-1:0]   mem_be_l2;
  logic [ADDR_W-1:0] mem_addr_l2;
  logic [DATA_W-1:0] mem_wdata_l2, if_rdata_l2, ls_rdata_l2;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_l1, starve_hit_cnt_l1;
  logic [31:0] conflict_cnt_l2, starve_hit_cnt_l2;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_l1), .if_rvalid_o(if_rvalid_l1), .if_rdata_o(if_rdata_l1),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_l1), .ls_rvalid_o(ls_rvalid_l1), .ls_rdata_o(ls_rdata_l1),
`ifdef ARB_PERF_CNT_EN
    .conflict_cnt_o(conflict_cnt_l1), .starve_hit_cnt_o(starve_hit_cnt_l1),
`endif
    .mem_req_o(mem_req_l1), .mem_we_o(mem_we_l1), .mem_be_o(mem_be_l1), .mem_addr_o(mem_addr_l1),
    .mem_wdata_o(mem_wdata_l1), .mem_rdata_i(mem_rdata_i)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(STARVE_MAX)) u_lat2 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_l2), .if_rvalid_o(if_rvalid_l2), .if_rdata_o(if_rdata_l2),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_l2), .ls_rvalid_o(ls_rvalid_l2), .ls_rdata_o(ls_rdata_l2),
`ifdef ARB_PERF_CNT_EN
    .conflict_cnt_o(conflict_cnt_l2), .starve_hit_cnt_o(starve_hit_cnt_l2),
`endif
    .mem_req_o(mem_req_l2), .mem_we_o(mem_we_l2), .mem_be_o(mem_be_l2), .mem_addr_o(mem_addr_l2),
    .mem_wdata_o(mem_wdata_l2), .mem_rdata_i(mem_rdata_i)
  );

  // Reference model state, indexed by the cycle a read was issued.
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          losses;
  int unsigned conflicts;
  int unsigned hits;
  bit          issued   [NCYC];
  bit          owner_if [NCYC];
  bit          alive1   [NCYC];
  bit          alive2   [NCYC];
  bit          exp_if_gnt, exp_ls_gnt;
  bit          obs_if_gnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ifr, input logic [31:0] ifa, input bit flush,
                               input bit lsr, input bit we, input logic [3:0] be,
                               input logic [31:0] lsa, input logic [31:0] wd);
    reset       = rst;
    if_req_i    = ifr;
    if_addr_i   = ifa;
    if_flush_i  = flush;
    ls_req_i    = lsr;
    ls_we_i     = we;
    ls_be_i     = be;
    ls_addr_i   = lsa;
    ls_wdata_i  = wd;
    mem_rdata_i = $urandom;
  endtask

  function automatic bit expRvalid(input int lat, input bit want_if);
    int c;
    bit alive;
    c = cyc - lat;
    if (reset || c < 0) return 1'b0;
    alive = (lat == 1) ? alive1[c] : alive2[c];
    return issued[c] && alive && (owner_if[c] == want_if) && !(want_if && if_flush_i);
  endfunction

  task automatic checkPort(input string sfx, input int lat,
                           input logic ig, input logic lg, input logic mr, input logic mw,
                           input logic [3:0] mb, input logic [31:0] ma, input logic [31:0] mwd,
                           input logic irv, input logic lrv, input logic [31:0] ird, input logic [31:0] lrd);
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    bit          e_we;
    e_we = 1'b0; e_be = 4'h0; e_addr = '0; e_wd = '0;
    if (exp_if_gnt) begin
      e_be = 4'hF; e_addr = if_addr_i;
    end else if (exp_ls_gnt) begin
      e_we = ls_we_i; e_be = ls_be_i; e_addr = ls_addr_i; e_wd = ls_wdata_i;
    end
    checkOutput({"if_gnt", sfx},    64'(ig),  64'(exp_if_gnt));
    checkOutput({"ls_gnt", sfx},    64'(lg),  64'(exp_ls_gnt));
    checkOutput({"mem_req", sfx},   64'(mr),  64'(exp_if_gnt || exp_ls_gnt));
    checkOutput({"mem_we", sfx},    64'(mw),  64'(e_we));
    checkOutput({"mem_be", sfx},    64'(mb),  64'(e_be));
    checkOutput({"mem_addr", sfx},  64'(ma),  64'(e_addr));
    checkOutput({"mem_wdata", sfx}, 64'(mwd), 64'(e_wd));
    checkOutput({"if_rdata", sfx},  64'(ird), 64'(mem_rdata_i));
    checkOutput({"ls_rdata", sfx},  64'(lrd), 64'(mem_rdata_i));
    if (!reset) begin
      checkOutput({"if_rvalid", sfx}, 64'(irv), 64'(expRvalid(lat, 1'b1)));
      checkOutput({"ls_rvalid", sfx}, 64'(lrv), 64'(expRvalid(lat, 1'b0)));
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance the
  // model to what the next edge must produce, then cross the edge.
  task automatic step();
    #3;
    exp_if_gnt = !reset && if_req_i && (!ls_req_i || losses == STARVE_MAX);
    exp_ls_gnt = !reset && ls_req_i && !exp_if_gnt;
    obs_if_gnt = if_gnt_l1;
    checkPort("_l1", 1, if_gnt_l1, ls_gnt_l1, mem_req_l1, mem_we_l1, mem_be_l1, mem_addr_l1,
              mem_wdata_l1, if_rvalid_l1, ls_rvalid_l1, if_rdata_l1, ls_rdata_l1);
    checkPort("_l2", 2, if_gnt_l2, ls_gnt_l2, mem_req_l2, mem_we_l2, mem_be_l2, mem_addr_l2,
              mem_wdata_l2, if_rvalid_l2, ls_rvalid_l2, if_rdata_l2, ls_rdata_l2);
`ifdef ARB_PERF_CNT_EN
    checkOutput("conflict_cnt_l1",   64'(conflict_cnt_l1),   64'(conflicts));
    checkOutput("starve_hit_cnt_l1", 64'(starve_hit_cnt_l1), 64'(hits));
    checkOutput("conflict_cnt_l2",   64'(conflict_cnt_l2),   64'(conflicts));
    checkOutput("starve_hit_cnt_l2", 64'(starve_hit_cnt_l2), 64'(hits));
`endif
    if (reset) begin
      losses    = 0;
      conflicts = 0;
      hits      = 0;
      issued[cyc] = 1'b0;
      for (int c = cyc - 1; c <= cyc; c++) begin
        if (c >= 0) begin
          alive1[c] = 1'b0;
          alive2[c] = 1'b0;
        end
      end
    end else begin
      if (if_flush_i) begin
        for (int c = cyc - 2; c < cyc; c++) begin
          if (c >= 0 && owner_if[c]) begin
            alive2[c] = 1'b0;
            if (c == cyc - 1) alive1[c] = 1'b0;
          end
        end
      end
      issued[cyc]   = exp_if_gnt || (exp_ls_gnt && !ls_we_i);
      owner_if[cyc] = exp_if_gnt;
      alive1[cyc]   = 1'b1;
      alive2[cyc]   = 1'b1;
      if (if_req_i && !exp_if_gnt) losses = (losses < STARVE_MAX) ? losses + 1 : STARVE_MAX;
      else                         losses = 0;
      if (if_req_i && ls_req_i)    conflicts = conflicts + 1;
      if (exp_if_gnt && ls_req_i)  hits = hits + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    logic [9:0] order_pat;
    bit         ifr, lsr, we, rst, flush;
    logic [31:0] ifa, lsa, wd;
    logic [3:0]  be;

    cyc = 0; n_checks = 0; n_fail = 0; losses = 0; conflicts = 0; hits = 0;
    #1;
    applyStimulus(1, 1, 32'h100, 0, 1, 0, 4'hF, 32'h200, 32'h0);
    step();
    step();

    // IF-only fetch stream, back-to-back grants.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h8000_0000 + 32'(4 * i), 0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
    end
    idle();
    idle();

    // Held conflict after a reset: LLLLI LLLLI (bit = IF won).
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    order_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 32'h8000_0040, 0, 1, 0, 4'hF, 32'h8000_2000, 32'h0);
      step();
      checkOutput("conflict_order", 64'(obs_if_gnt), 64'(order_pat[i]));
    end
`ifdef ARB_PERF_CNT_EN
    checkOutput("conflict_cnt_end",   64'(conflict_cnt_l1),   64'd10);
    checkOutput("starve_hit_cnt_end", 64'(starve_hit_cnt_l1), 64'd2);
`endif
    idle();
    idle();

    // Partial-word store.
    applyStimulus(0, 0, 32'h0, 0, 1, 1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF);
    step();
    idle();
    idle();
    idle();

    // Flush while IF reads are in flight behind an LS load.
    applyStimulus(0, 1, 32'h8000_0100, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    applyStimulus(0, 1, 32'h8000_0104, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    applyStimulus(0, 0, 32'h0, 1, 1, 0, 4'hF, 32'h8000_3000, 32'h0);
    step();
    idle();
    idle();
    idle();

    // Reset with reads in flight, then IF must win straight away.
    applyStimulus(0, 1, 32'h8000_0200, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 4'hF, 32'h8000_4000, 32'h0);
    step();
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    applyStimulus(0, 1, 32'h8000_0300, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    idle();
    idle();

    // Random traffic: requests held with stable fields until granted.
    ifr = 0; lsr = 0; we = 0; ifa = '0; lsa = '0; wd = '0; be = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!ifr || exp_if_gnt || reset) begin
        ifr = ($urandom_range(0, 2) != 0);
        ifa = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      end
      if (!lsr || exp_ls_gnt || reset) begin
        lsr = ($urandom_range(0, 2) != 0);
        we  = ($urandom_range(0, 3) == 0);
        be  = 4'($urandom);
        lsa = $urandom;
        wd  = $urandom;
      end
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 7) == 0);
      applyStimulus(rst, ifr, ifa, flush, lsr, we, be, lsa, wd);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
